// File: rtl/dat_transfer_scheduler.sv
// Arbitrates two data requesters onto one physical data controller and sequences
// each transfer through strobe, completion/timeout retry, acknowledge and report.
module dat_transfer_scheduler #(
    parameter int          MAX_RETRIES  = 2,
    parameter logic [15:0] TIMEOUT_DFLT = 16'hFFFF
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        req_wr,
    input  logic        req_rd,
    input  logic [3:0]  wr_blocks,
    input  logic [3:0]  rd_blocks,
    input  logic [15:0] timeout_cfg,
    output logic        grant_wr,
    output logic        grant_rd,
    output logic        done,
    output logic        done_id,
    output logic        error,
    output logic        busy,
    output logic        phy_strobe,
    output logic        phy_writeRead,
    output logic        phy_multiple,
    output logic [3:0]  phy_blocks,
    output logic [15:0] phy_timeout_reg,
    output logic        phy_ack,
    output logic        phy_idle,
    input  logic        phy_serial_ready,
    input  logic        phy_complete,
    input  logic        phy_ack_in,
    input  logic        phy_timeout
);

    localparam int RW = $clog2(MAX_RETRIES + 2);

    typedef enum logic [2:0] {
        IDLE, ARB, ISSUE, WAIT_DONE, ABORT, ACK, REPORT
    } state_t;

    state_t          state, state_nxt;
    logic            prio_rd, prio_rd_nxt;   // 1: read wins a tie
    logic            cur_rd, cur_rd_nxt;     // requester owning the current transfer
    logic [RW-1:0]   retry, retry_nxt;

    logic            grant_wr_nxt, grant_rd_nxt, done_nxt, done_id_nxt, error_nxt;
    logic            busy_nxt, strobe_nxt, wr_nxt, mult_nxt, ack_nxt, idle_nxt;
    logic [3:0]      blocks_nxt;
    logic [15:0]     tmo_nxt;
    logic            win_rd;
    logic [3:0]      win_blocks;

    // Winner is picked on the IDLE->ARB edge so the grant is already visible in ARB.
    assign win_rd     = req_rd && (!req_wr || prio_rd);
    assign win_blocks = win_rd ? rd_blocks : wr_blocks;

    always_comb begin
        state_nxt    = state;
        prio_rd_nxt  = prio_rd;
        cur_rd_nxt   = cur_rd;
        retry_nxt    = retry;
        grant_wr_nxt = grant_wr;
        grant_rd_nxt = grant_rd;
        blocks_nxt   = phy_blocks;
        wr_nxt       = phy_writeRead;
        mult_nxt     = phy_multiple;
        tmo_nxt      = phy_timeout_reg;
        ack_nxt      = phy_ack;
        done_nxt     = 1'b0;
        done_id_nxt  = 1'b0;
        error_nxt    = 1'b0;
        strobe_nxt   = 1'b0;
        idle_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (req_wr || req_rd) begin
                    state_nxt    = ARB;
                    cur_rd_nxt   = win_rd;
                    grant_wr_nxt = !win_rd;
                    grant_rd_nxt = win_rd;
                    blocks_nxt   = win_blocks;
                    wr_nxt       = !win_rd;
                    mult_nxt     = (win_blocks > 4'd1);
                    tmo_nxt      = (timeout_cfg == 16'h0000) ? TIMEOUT_DFLT : timeout_cfg;
                    retry_nxt    = '0;
                end
            end
            ARB: begin
                if (phy_blocks == 4'd0) begin
                    state_nxt   = REPORT;
                    done_nxt    = 1'b1;
                    done_id_nxt = cur_rd;
                    error_nxt   = 1'b1;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (phy_serial_ready) begin
                    state_nxt  = WAIT_DONE;
                    strobe_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                // Completion takes priority over a coincident timeout.
                if (phy_complete) begin
                    state_nxt = ACK;
                    ack_nxt   = 1'b1;
                end else if (phy_timeout) begin
                    state_nxt = ABORT;
                    idle_nxt  = 1'b1;
                end
            end
            ABORT: begin
                retry_nxt = retry + RW'(1);
                if (retry < RW'(MAX_RETRIES)) begin
                    state_nxt = ISSUE;
                end else begin
                    state_nxt   = REPORT;
                    done_nxt    = 1'b1;
                    done_id_nxt = cur_rd;
                    error_nxt   = 1'b1;
                end
            end
            ACK: begin
                if (phy_ack_in) begin
                    state_nxt   = REPORT;
                    ack_nxt     = 1'b0;
                    done_nxt    = 1'b1;
                    done_id_nxt = cur_rd;
                end
            end
            REPORT: begin
                state_nxt    = IDLE;
                prio_rd_nxt  = !cur_rd;
                grant_wr_nxt = 1'b0;
                grant_rd_nxt = 1'b0;
                blocks_nxt   = 4'd0;
                wr_nxt       = 1'b0;
                mult_nxt     = 1'b0;
                tmo_nxt      = 16'h0000;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            prio_rd         <= 1'b0;
            cur_rd          <= 1'b0;
            retry           <= '0;
            grant_wr        <= 1'b0;
            grant_rd        <= 1'b0;
            done            <= 1'b0;
            done_id         <= 1'b0;
            error           <= 1'b0;
            busy            <= 1'b0;
            phy_strobe      <= 1'b0;
            phy_writeRead   <= 1'b0;
            phy_multiple    <= 1'b0;
            phy_blocks      <= 4'd0;
            phy_timeout_reg <= 16'h0000;
            phy_ack         <= 1'b0;
            phy_idle        <= 1'b0;
        end else begin
            state           <= state_nxt;
            prio_rd         <= prio_rd_nxt;
            cur_rd          <= cur_rd_nxt;
            retry           <= retry_nxt;
            grant_wr        <= grant_wr_nxt;
            grant_rd        <= grant_rd_nxt;
            done            <= done_nxt;
            done_id         <= done_id_nxt;
            error           <= error_nxt;
            busy            <= busy_nxt;
            phy_strobe      <= strobe_nxt;
            phy_writeRead   <= wr_nxt;
            phy_multiple    <= mult_nxt;
            phy_blocks      <= blocks_nxt;
            phy_timeout_reg <= tmo_nxt;
            phy_ack         <= ack_nxt;
            phy_idle        <= idle_nxt;
        end
    end

endmodule

// File: tb/tb_dat_transfer_scheduler.sv
// Directed rounds against a reactive PHY model; a negedge monitor scores each done pulse.
module tb_dat_transfer_scheduler;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_wr = 1'b0, req_rd = 1'b0;
    logic [3:0]  wr_blocks = 4'd0, rd_blocks = 4'd0;
    logic [15:0] timeout_cfg = 16'h0000;
    logic        grant_wr, grant_rd, done, done_id, error, busy;
    logic        phy_strobe, phy_writeRead, phy_multiple, phy_ack, phy_idle;
    logic [3:0]  phy_blocks;
    logic [15:0] phy_timeout_reg;
    logic        phy_serial_ready = 1'b0, phy_complete = 1'b0;
    logic        phy_ack_in = 1'b0, phy_timeout = 1'b0;

    dat_transfer_scheduler dut (
        .sd_clock(sd_clock), .reset(reset),
        .req_wr(req_wr), .req_rd(req_rd),
        .wr_blocks(wr_blocks), .rd_blocks(rd_blocks), .timeout_cfg(timeout_cfg),
        .grant_wr(grant_wr), .grant_rd(grant_rd),
        .done(done), .done_id(done_id), .error(error), .busy(busy),
        .phy_strobe(phy_strobe), .phy_writeRead(phy_writeRead), .phy_multiple(phy_multiple),
        .phy_blocks(phy_blocks), .phy_timeout_reg(phy_timeout_reg),
        .phy_ack(phy_ack), .phy_idle(phy_idle),
        .phy_serial_ready(phy_serial_ready), .phy_complete(phy_complete),
        .phy_ack_in(phy_ack_in), .phy_timeout(phy_timeout)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct {
        logic        id;
        logic        err;
        int          strobes;
        int          idles;
        logic [3:0]  blocks;
        logic        wr;
        logic        mult;
        logic [15:0] tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mon_str = 0;
    int   mon_idl = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {grant_wr, grant_rd, done, done_id, error, busy, phy_strobe, phy_writeRead,
                phy_multiple, phy_blocks, phy_timeout_reg, phy_ack, phy_idle};
    endfunction

    // Monitor: counts strobe/idle pulses per transfer and scores each done.
    always @(negedge sd_clock) begin
        exp_t e;
        if (!reset) begin
            mon_str = 0;
            mon_idl = 0;
        end else begin
            chk("grant_exclusive", {31'd0, grant_wr & grant_rd}, 32'd0);
            if (phy_strobe) mon_str++;
            if (phy_idle)   mon_idl++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("done_id",    {31'd0, done_id},       {31'd0, e.id});
                    chk("error",      {31'd0, error},         {31'd0, e.err});
                    chk("strobes",    mon_str,                e.strobes);
                    chk("idles",      mon_idl,                e.idles);
                    chk("phy_blocks", {28'd0, phy_blocks},    {28'd0, e.blocks});
                    chk("writeRead",  {31'd0, phy_writeRead}, {31'd0, e.wr});
                    chk("multiple",   {31'd0, phy_multiple},  {31'd0, e.mult});
                    chk("timeout_reg",{16'd0, phy_timeout_reg}, {16'd0, e.tmo});
                    chk("grant",      {30'd0, grant_wr, grant_rd}, {30'd0, ~e.id, e.id});
                    chk("busy",       {31'd0, busy},          32'd1);
                end
                mon_str = 0;
                mon_idl = 0;
            end
        end
    end

    // One transfer round; n_to = timeouts injected before completion.
    task automatic round(input bit rw, input bit rr, input logic [3:0] wb, input logic [3:0] rb,
                         input logic [15:0] tcfg, input int n_to, input bit both, input int rdy_dly,
                         input bit e_id, input bit e_err, input int e_str, input int e_idl,
                         input logic [3:0] e_blk, input bit e_wr, input bit e_mult,
                         input logic [15:0] e_tmo);
        exp_t e;
        int   attempt, pend, cyc;
        bit   fin;
        e.id = e_id; e.err = e_err; e.strobes = e_str; e.idles = e_idl;
        e.blocks = e_blk; e.wr = e_wr; e.mult = e_mult; e.tmo = e_tmo;
        sb.push_back(e);
        req_wr = rw; req_rd = rr; wr_blocks = wb; rd_blocks = rb; timeout_cfg = tcfg;
        phy_serial_ready = (rdy_dly == 0);
        attempt = 0; pend = 0; cyc = 0; fin = 0;
        while (!fin && cyc < 300) begin
            @(negedge sd_clock);
            cyc++;
            phy_timeout = 1'b0;
            if (cyc >= rdy_dly) phy_serial_ready = 1'b1;
            if (phy_strobe) begin
                attempt++;
                pend = 2;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (attempt <= n_to) phy_timeout = 1'b1;
                    else begin
                        phy_complete = 1'b1;
                        phy_timeout  = both;
                    end
                end
            end
            if (phy_ack) begin
                phy_complete = 1'b0;
                phy_ack_in   = 1'b1;
            end else begin
                phy_ack_in = 1'b0;
            end
            if (done) begin
                fin = 1;
                req_wr = 1'b0; req_rd = 1'b0;
                phy_complete = 1'b0; phy_ack_in = 1'b0;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL round_timeout actual=no_done required=done");
        end
    endtask

    initial begin
        int  cyc;
        int  dcnt;
        bit  seen;
        #1;
        @(negedge sd_clock);
        chk("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        @(negedge sd_clock);

        // contention x3 from reset pointer: write, read, write
        round(1, 1, 4'd2, 4'd5, 16'h0200, 0, 0, 0, 0, 0, 1, 0, 4'd2, 1, 1, 16'h0200);
        round(1, 1, 4'd2, 4'd5, 16'h0200, 0, 0, 0, 1, 0, 1, 0, 4'd5, 0, 1, 16'h0200);
        round(1, 1, 4'd2, 4'd5, 16'h0200, 0, 0, 0, 0, 0, 1, 0, 4'd2, 1, 1, 16'h0200);
        // single write, 3 blocks
        round(1, 0, 4'd3, 4'd0, 16'h0100, 0, 0, 0, 0, 0, 1, 0, 4'd3, 1, 1, 16'h0100);
        // retry: two timeouts then complete
        round(0, 1, 4'd0, 4'd1, 16'h0080, 2, 0, 0, 1, 0, 3, 2, 4'd1, 0, 0, 16'h0080);
        // exhaustion
        round(1, 0, 4'd2, 4'd0, 16'h0030, 5, 0, 0, 0, 1, 3, 3, 4'd2, 1, 1, 16'h0030);
        // zero-block read rejected
        round(0, 1, 4'd0, 4'd0, 16'h0010, 0, 0, 0, 1, 1, 0, 0, 4'd0, 0, 0, 16'h0010);
        // complete and timeout together
        round(0, 1, 4'd0, 4'd4, 16'h0500, 0, 1, 0, 1, 0, 1, 0, 4'd4, 0, 1, 16'h0500);
        // timeout_cfg 0 selects default, serial_ready late
        round(1, 0, 4'd1, 4'd0, 16'h0000, 0, 0, 3, 0, 0, 1, 0, 4'd1, 1, 0, 16'hFFFF);

        // reset during WAIT_DONE of a read (pointer currently favours read)
        req_rd = 1'b1; rd_blocks = 4'd2; timeout_cfg = 16'h0040; phy_serial_ready = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 50) begin
            @(negedge sd_clock);
            cyc++;
            if (phy_strobe) seen = 1;
        end
        chk("rst_reach_wait", {31'd0, seen}, 32'd1);
        reset = 1'b0;
        req_rd = 1'b0;
        #1;
        chk("rst_mid_outputs", all_outs(), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sd_clock);
            if (done) dcnt++;
            if (i == 1) reset = 1'b1;
        end
        chk("rst_no_done", dcnt, 32'd0);
        round(1, 1, 4'd6, 4'd7, 16'h0020, 0, 0, 0, 0, 0, 1, 0, 4'd6, 1, 1, 16'h0020);

        repeat (3) @(negedge sd_clock);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dat_transfer_scheduler.md
DAT_TRANSFER_SCHEDULER -- requirements
Module: dat_transfer_scheduler

Interface
REQ-001 Parameter MAX_RETRIES, default 2: number of timeout-triggered re-issues allowed per transfer before an error is reported.
REQ-002 Parameter TIMEOUT_DFLT, default 16'hFFFF: value driven on phy_timeout_reg when timeout_cfg is 0.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- sd_clock  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- req_wr  in  1  write requester request; held high until done.
- req_rd  in  1  read requester request; held high until done.
- wr_blocks  in  4  block count for a write request.
- rd_blocks  in  4  block count for a read request.
- timeout_cfg  in  16  data timeout setting.
- grant_wr  out  1  write requester owns the physical data controller.
- grant_rd  out  1  read requester owns the physical data controller.
- done  out  1  one-cycle transfer-finished pulse.
- done_id  out  1  requester that finished: 0 = write, 1 = read; valid with done.
- error  out  1  qualifies done: transfer failed.
- busy  out  1  high in every state except IDLE.
- phy_strobe  out  1  request to the physical data controller.
- phy_writeRead  out  1  1 = write, 0 = read.
- phy_multiple  out  1  multi-block transfer.
- phy_blocks  out  4  block count.
- phy_timeout_reg  out  16  timeout value for the physical data controller.
- phy_ack  out  1  acknowledges completion to the physical data controller.
- phy_idle  out  1  forces the physical data controller back to IDLE.
- phy_serial_ready  in  1  physical data controller is idle and accepting a strobe.
- phy_complete  in  1  physical data controller has finished the transfer.
- phy_ack_in  in  1  physical data controller echoes phy_ack.
- phy_timeout  in  1  physical data controller DATA_TIMEOUT flag.

Function
REQ-004 The FSM SHALL have seven states: IDLE, ARB, ISSUE, WAIT_DONE, ABORT, ACK, REPORT; all outputs are registered.
REQ-005 IDLE SHALL go to ARB when req_wr or req_rd is high, and otherwise stay in IDLE.
REQ-006 ARB SHALL arbitrate round-robin:
- Only one requester high: grant it.
- Both high: grant the requester not granted last; the pointer after reset favours write.
- Grant the winner for one cycle, then go to ISSUE.
REQ-007 ARB SHALL latch the transaction for the winner:
- blocks = wr_blocks or rd_blocks.
- phy_writeRead = 1 for write, 0 for read.
- phy_multiple = (blocks > 1).
- phy_timeout_reg = timeout_cfg, or TIMEOUT_DFLT when timeout_cfg == 0.
- retry counter cleared to 0.
REQ-008 ARB SHALL reject a zero-block request: if the latched blocks == 0, go directly to REPORT with error = 1 and issue no phy_strobe.
REQ-009 A grant SHALL stay high from ARB through REPORT inclusive, and grant_wr and grant_rd SHALL never be high together.
REQ-010 ISSUE SHALL wait while phy_serial_ready = 0; on the first cycle phy_serial_ready = 1 it asserts phy_strobe for exactly one cycle and goes to WAIT_DONE.
REQ-011 WAIT_DONE SHALL branch on the physical data controller flags:
- phy_complete = 1: go to ACK.
- phy_timeout = 1 and phy_complete = 0: go to ABORT.
- Both high in the same cycle: phy_complete wins.
REQ-012 ABORT SHALL assert phy_idle for one cycle and increment the retry counter, then:
- retry counter before increment < MAX_RETRIES: go to ISSUE.
- Otherwise: go to REPORT with error = 1.
REQ-013 ACK SHALL hold phy_ack = 1 until phy_ack_in = 1, then go to REPORT with error = 0.
REQ-014 REPORT SHALL pulse done for one cycle with done_id and error valid, drop the grant, update the round-robin pointer, and go to IDLE.
REQ-015 A requester deasserting req mid-transfer SHALL be ignored: the transfer runs to REPORT.
REQ-016 A req still high in IDLE after REPORT SHALL be treated as a new request.
REQ-017 Request latency: a request seen in IDLE at cycle N gives phy_strobe no earlier than cycle N+2.
REQ-018 phy_writeRead, phy_multiple, phy_blocks and phy_timeout_reg SHALL remain stable from ARB until the end of REPORT.

Reset
REQ-019 While reset = 0, the block SHALL be in IDLE with every output 0, the retry counter 0 and the round-robin pointer favouring write.
REQ-020 Reset asserted mid-operation SHALL abort immediately with no done pulse; after release the block restarts from IDLE.

Verification
REQ-021 Single write: req_wr = 1, wr_blocks = 3, phy_serial_ready = 1 -> grant_wr, one phy_strobe with phy_writeRead = 1, phy_multiple = 1, phy_blocks = 3; then phy_complete -> phy_ack until phy_ack_in; then done = 1, done_id = 0, error = 0.
REQ-022 Contention: req_wr and req_rd both high in three successive rounds -> grants in order write, read, write.
REQ-023 Retry: phy_timeout pulses twice, then phy_complete -> two phy_idle pulses, three phy_strobe pulses, and done with error = 0.
REQ-024 Exhaustion: phy_timeout on every attempt -> three phy_strobe pulses, then done with error = 1, done_id matching the requester.
REQ-025 Boundaries:
- rd_blocks = 0 -> done with error = 1 and no phy_strobe.
- timeout_cfg = 0 -> phy_timeout_reg = 16'hFFFF.
- phy_timeout and phy_complete high in the same cycle -> ACK path is taken.
REQ-026 Reset pulsed low during WAIT_DONE -> all outputs 0 immediately, no done pulse, and the next contention round grants write.
